// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the RV32I main decoder.
//   - Opcode encodings (instr[6:0]) for every opcode the decoder recognises.
//   - ALUOp encodings consumed by the downstream ALU-control block.
//   - ctrl_t: the bundle of control strobes produced by control_decode.
// Optional feature macro: CTRL_ILLEGAL_OP_EN adds the illegal flag to ctrl_t.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // funct7 values accepted for R-type (base and sub/sra variants).
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
`ifdef CTRL_ILLEGAL_OP_EN
    logic       illegal;
`endif
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction fields in, registered control strobes out.
//   slave  : the decoder side (receives opcode/funct3/funct7, drives controls).
//   master : the fetch/issue side (drives instruction fields, observes controls).
// Signals:
//   opcode[6:0], funct3[2:0], funct7[6:0]        instruction fields
//   RegWrite, MemWrite, MemRead, MemToReg,
//   ALUSrc, Branch, Jump, ALUOp[1:0]             datapath controls
//   illegal                                      only with CTRL_ILLEGAL_OP_EN
interface control_unit_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemRead;
  logic       MemToReg;
  logic       ALUSrc;
  logic       Branch;
  logic       Jump;
  logic [1:0] ALUOp;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       illegal;
`endif

  modport master (
    output opcode, funct3, funct7,
`ifdef CTRL_ILLEGAL_OP_EN
    input  illegal,
`endif
    input  RegWrite, MemWrite, MemRead, MemToReg, ALUSrc, Branch, Jump, ALUOp
  );

  modport slave (
    input  opcode, funct3, funct7,
`ifdef CTRL_ILLEGAL_OP_EN
    output illegal,
`endif
    output RegWrite, MemWrite, MemRead, MemToReg, ALUSrc, Branch, Jump, ALUOp
  );

endinterface

// File: rtl/control_decode.sv
// control_decode: purely combinational RV32I main decode.
//   opcode_i[6:0]  instr[6:0]
//   funct3_i[2:0]  instr[14:12] (only examined with CTRL_ILLEGAL_OP_EN)
//   funct7_i[6:0]  instr[31:25] (only examined with CTRL_ILLEGAL_OP_EN)
//   ctrl_o         control bundle; all-zero for unrecognised opcodes
// With CTRL_ILLEGAL_OP_EN, malformed encodings raise ctrl_o.illegal and squash
// every other strobe so an illegal instruction behaves as a bubble downstream.
module control_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o
);

  ctrl_t base;

  always_comb begin
    base = '0;
    case (opcode_i)
      OP_R: begin
        base.reg_write = 1'b1;
        base.alu_op    = ALUOP_R;
      end
      OP_IMM: begin
        base.reg_write = 1'b1;
        base.alu_src   = 1'b1;
        base.alu_op    = ALUOP_I;
      end
      OP_LOAD: begin
        base.reg_write  = 1'b1;
        base.mem_read   = 1'b1;
        base.mem_to_reg = 1'b1;
        base.alu_src    = 1'b1;
      end
      OP_STORE: begin
        base.mem_write = 1'b1;
        base.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        base.branch = 1'b1;
        base.alu_op = ALUOP_BR;
      end
      OP_JAL: begin
        base.reg_write = 1'b1;
        base.jump      = 1'b1;
      end
      OP_JALR: begin
        base.reg_write = 1'b1;
        base.jump      = 1'b1;
        base.alu_src   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        base.reg_write = 1'b1;
        base.alu_src   = 1'b1;
      end
      default: base = '0;
    endcase
  end

`ifdef CTRL_ILLEGAL_OP_EN
  logic bad;

  always_comb begin
    bad = 1'b0;
    case (opcode_i)
      OP_R: begin
        bad = !(funct7_i inside {F7_BASE, F7_ALT}) ||
              ((funct7_i == F7_ALT) && !(funct3_i inside {3'b000, 3'b101}));
      end
      OP_LOAD:   bad = funct3_i inside {3'b011, 3'b110, 3'b111};
      OP_STORE:  bad = funct3_i > 3'b010;
      OP_BRANCH: bad = funct3_i inside {3'b010, 3'b011};
      OP_JALR:   bad = funct3_i != 3'b000;
      OP_IMM, OP_JAL, OP_LUI, OP_AUIPC: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
  end

  always_comb begin
    ctrl_o = base;
    if (bad) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
    end
  end
`else
  // funct fields only matter for legality checking.
  logic unused_funct;
  assign unused_funct = ^{funct3_i, funct7_i};
  assign ctrl_o       = base;
`endif

endmodule

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder for the ID stage with a registered output stage.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears every output, has priority
//   bus  control_unit_if.slave: opcode/funct3/funct7 in, control strobes out
// Outputs reflect the decode of the inputs present at the previous rising edge.
// Optional feature macro: CTRL_ILLEGAL_OP_EN (adds the registered illegal output).
module control_unit
  import ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  control_unit_if.slave bus
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .opcode_i (bus.opcode),
    .funct3_i (bus.funct3),
    .funct7_i (bus.funct7),
    .ctrl_o   (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemToReg = ctrl_q.mem_to_reg;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.Branch   = ctrl_q.branch;
  assign bus.Jump     = ctrl_q.jump;
  assign bus.ALUOp    = ctrl_q.alu_op;
`ifdef CTRL_ILLEGAL_OP_EN
  assign bus.illegal  = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized + directed bench for control_unit.
// Output vector layout used throughout:
//   {illegal, RegWrite, MemWrite, MemRead, MemToReg, ALUSrc, Branch, Jump, ALUOp[1:0]}
// illegal is 0 when CTRL_ILLEGAL_OP_EN is not defined.
module tb_control_unit;

  logic clk;
  logic rst;
  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference decode table: {opcode, RegWrite, MemWrite, MemRead, MemToReg, ALUSrc,
  // Branch, Jump, ALUOp}.
  localparam logic [15:0] TBL [9] = '{
    {7'b0110011, 7'b1000000, 2'b10},  // R-type
    {7'b0010011, 7'b1000100, 2'b11},  // I-ALU
    {7'b0000011, 7'b1011100, 2'b00},  // load
    {7'b0100011, 7'b0100100, 2'b00},  // store
    {7'b1100011, 7'b0000010, 2'b01},  // branch
    {7'b1101111, 7'b1000001, 2'b00},  // jal
    {7'b1100111, 7'b1000101, 2'b00},  // jalr
    {7'b0110111, 7'b1000100, 2'b00},  // lui
    {7'b0010111, 7'b1000100, 2'b00}   // auipc
  };

  function automatic logic [9:0] model(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
    logic [8:0] ctl;
    bit         found;
    bit         ill;
    ctl   = '0;
    found = 0;
    for (int i = 0; i < 9; i++) begin
      if (TBL[i][15:9] == op) begin
        found = 1;
        ctl   = TBL[i][8:0];
      end
    end
    ill = 0;
`ifdef CTRL_ILLEGAL_OP_EN
    if (!found) ill = 1;
    if (op == 7'b0110011) begin
      if (f7 != 7'd0 && f7 != 7'd32) ill = 1;
      if (f7 == 7'd32 && f3 != 3'd0 && f3 != 3'd5) ill = 1;
    end
    if (op == 7'b0000011 && (f3 == 3'd3 || f3 >= 3'd6)) ill = 1;
    if (op == 7'b0100011 && f3 > 3'd2) ill = 1;
    if (op == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3)) ill = 1;
    if (op == 7'b1100111 && f3 != 3'd0) ill = 1;
`else
    if (found && (f3 === 3'bx) && (f7 === 7'bx)) ill = 0;
`endif
    return ill ? 10'b10_0000_0000 : {1'b0, ctl};
  endfunction

  function automatic logic [9:0] dut_vec();
    logic ill;
`ifdef CTRL_ILLEGAL_OP_EN
    ill = bus.illegal;
`else
    ill = 1'b0;
`endif
    return {ill, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.MemToReg, bus.ALUSrc,
            bus.Branch, bus.Jump, bus.ALUOp};
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle scoreboard: expectation captured at each rising edge, checked mid-cycle.
  logic [9:0] exp_q;
  bit         exp_valid = 0;

  always @(posedge clk) begin
    exp_q     <= rst ? 10'b0 : model(bus.opcode, bus.funct3, bus.funct7);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("cycle", dut_vec(), exp_q);
      chk("mem_excl", {9'b0, bus.MemRead & bus.MemWrite}, 10'b0);
      chk("jmp_excl", {9'b0, bus.Jump & bus.Branch}, 10'b0);
    end
  end

  task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    @(negedge clk);
    rst        = r;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // Pin the model against a hand-written value, then apply and check the DUT directly.
  task automatic lit(input string name, input logic r, input logic [6:0] op,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [9:0] exp);
    if (!r) chk({name, "_model"}, model(op, f3, f7), exp);
    drive(r, op, f3, f7);
    @(posedge clk);
    #1;
    chk(name, dut_vec(), exp);
  endtask

  localparam logic [9:0] ZERO = 10'b0;
`ifdef CTRL_ILLEGAL_OP_EN
  localparam logic [9:0] BAD_OP = 10'b10_0000_0000;
`else
  localparam logic [9:0] BAD_OP = 10'b0;
`endif

  logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000,
                           7'b1111111};

  initial begin
    rst        = 1'b1;
    bus.opcode = 7'b0110011;
    bus.funct3 = 3'b000;
    bus.funct7 = 7'b0000000;

    // Reset held for two edges with an R-type on the inputs.
    @(posedge clk);
    #1;
    chk("rst_edge1", dut_vec(), ZERO);
    @(posedge clk);
    #1;
    chk("rst_edge2", dut_vec(), ZERO);
    lit("r_after_rst", 1'b0, 7'b0110011, 3'b000, 7'd0, {1'b0, 7'b1000000, 2'b10});

    lit("r_type", 1'b0, 7'b0110011, 3'b000, 7'd0, {1'b0, 7'b1000000, 2'b10});
    lit("load",   1'b0, 7'b0000011, 3'b010, 7'd0, {1'b0, 7'b1011100, 2'b00});
    lit("store",  1'b0, 7'b0100011, 3'b010, 7'd0, {1'b0, 7'b0100100, 2'b00});
    lit("branch", 1'b0, 7'b1100011, 3'b000, 7'd0, {1'b0, 7'b0000010, 2'b01});
    lit("jal",    1'b0, 7'b1101111, 3'b000, 7'd0, {1'b0, 7'b1000001, 2'b00});
    lit("jalr",   1'b0, 7'b1100111, 3'b000, 7'd0, {1'b0, 7'b1000101, 2'b00});
    lit("i_alu",  1'b0, 7'b0010011, 3'b001, 7'd0, {1'b0, 7'b1000100, 2'b11});
    lit("lui",    1'b0, 7'b0110111, 3'b000, 7'd0, {1'b0, 7'b1000100, 2'b00});
    lit("op_zero", 1'b0, 7'b0000000, 3'b000, 7'd0, BAD_OP);
    lit("op_ones", 1'b0, 7'b1111111, 3'b000, 7'd0, BAD_OP);
    lit("load_pre", 1'b0, 7'b0000011, 3'b000, 7'd0, {1'b0, 7'b1011100, 2'b00});
    lit("rst_mid",  1'b1, 7'b0000011, 3'b000, 7'd0, ZERO);
    lit("resume",   1'b0, 7'b0000011, 3'b000, 7'd0, {1'b0, 7'b1011100, 2'b00});
`ifdef CTRL_ILLEGAL_OP_EN
    lit("r_bad_f7",   1'b0, 7'b0110011, 3'b000, 7'b0000001, BAD_OP);
    lit("jalr_bad",   1'b0, 7'b1100111, 3'b001, 7'd0, BAD_OP);
    lit("r_sub",      1'b0, 7'b0110011, 3'b000, 7'b0100000, {1'b0, 7'b1000000, 2'b10});
    lit("r_alt_bad",  1'b0, 7'b0110011, 3'b001, 7'b0100000, BAD_OP);
    lit("store_bad",  1'b0, 7'b0100011, 3'b011, 7'd0, BAD_OP);
    lit("branch_bad", 1'b0, 7'b1100011, 3'b010, 7'd0, BAD_OP);
`else
    lit("r_funct_ign", 1'b0, 7'b0110011, 3'b111, 7'b1111111, {1'b0, 7'b1000000, 2'b10});
    lit("jalr_f3_ign", 1'b0, 7'b1100111, 3'b001, 7'd0, {1'b0, 7'b1000101, 2'b00});
`endif

    // Randomized traffic; the per-cycle scoreboard does the checking.
    for (int n = 0; n < 2000; n++) begin
      logic [6:0] op;
      logic [6:0] f7;
      logic       r;
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0:       f7 = 7'd0;
        1:       f7 = 7'd32;
        default: f7 = 7'($urandom);
      endcase
      r = ($urandom_range(0, 15) == 0);
      drive(r, op, 3'($urandom), f7);
    end

    drive(1'b0, 7'b0000000, 3'b000, 7'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
